// File: rtl/tex_addr_gen_pkg.sv
// -----------------------------------------------------------------------------
// tex_addr_gen_pkg
// Shared texture definitions: per-stage texture state as published by the
// texture CSR block, stage-index width, wrap-mode encoding and small helpers
// used by the texture address generator.
// -----------------------------------------------------------------------------
package tex_addr_gen_pkg;

    localparam int unsigned TEX_STAGE_BITS = 2;
    localparam int unsigned TEX_NUM_STAGES = 1 << TEX_STAGE_BITS;

    // Largest supported log2 texture dimension; wrapped coords fit in this many bits.
    localparam int unsigned TEX_COORD_BITS = 12;
    localparam logic [3:0]  TEX_MAX_LOG    = 4'd12;

    typedef enum logic [1:0] {
        TEX_WRAP_CLAMP  = 2'd0,
        TEX_WRAP_REPEAT = 2'd1,
        TEX_WRAP_MIRROR = 2'd2,
        TEX_WRAP_RSVD   = 2'd3
    } tex_wrap_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  logwidth;
        logic [3:0]  logheight;
        logic [1:0]  logstride;
        tex_wrap_e   wrap_u;
        tex_wrap_e   wrap_v;
    } tex_stage_t;

    typedef tex_stage_t [TEX_NUM_STAGES-1:0] tex_csrs_t;

    // Oversized texture dimensions are treated as the largest supported one.
    function automatic logic [3:0] tex_log_sat(input logic [3:0] lg);
        return (lg > TEX_MAX_LOG) ? TEX_MAX_LOG : lg;
    endfunction

    // Byte offset of texel (x,y) in a row-major texture whose row pitch is
    // one texture width; x < width always holds, so OR acts as an add.
    function automatic logic [31:0] tex_texel_offset(
        input logic [TEX_COORD_BITS-1:0] x,
        input logic [TEX_COORD_BITS-1:0] y,
        input logic [3:0]                logw,
        input logic [1:0]                logstride
    );
        logic [31:0] texel;
        texel = (32'(y) << logw) | 32'(x);
        return texel << logstride;
    endfunction

endpackage

// File: rtl/tex_wrap.sv
// -----------------------------------------------------------------------------
// tex_wrap
// Combinational wrap of one scaled texel coordinate on one axis.
//   xf       in  : signed integer texel coordinate (already scaled)
//   log_size in  : log2 of the axis size, already saturated to TEX_MAX_LOG
//   mode     in  : wrap mode (clamp / repeat / mirror; reserved acts as clamp)
//   coord    out : wrapped coordinate in [0, size-1]
// -----------------------------------------------------------------------------
module tex_wrap
    import tex_addr_gen_pkg::*;
(
    input  logic signed [31:0]         xf,
    input  logic [3:0]                 log_size,
    input  tex_wrap_e                  mode,
    output logic [TEX_COORD_BITS-1:0]  coord
);

    logic [TEX_COORD_BITS-1:0] max_coord;
    logic [TEX_COORD_BITS-1:0] low;
    logic                      over;

    always_comb begin
        max_coord = TEX_COORD_BITS'((13'd1 << log_size) - 13'd1);
        low       = xf[TEX_COORD_BITS-1:0] & max_coord;
        // For a non-negative xf, xf >= size exactly when bits above log_size exist.
        over      = (xf >>> log_size) != 32'sd0;

        coord = low;
        case (mode)
            TEX_WRAP_REPEAT: coord = low;
            // Odd periods run backwards; bit log_size selects the period parity.
            TEX_WRAP_MIRROR: coord = xf[log_size] ? (max_coord - low) : low;
            default: begin
                if (xf[31]) begin
                    coord = '0;
                end else if (over) begin
                    coord = max_coord;
                end else begin
                    coord = low;
                end
            end
        endcase
    end

endmodule

// File: rtl/tex_addr_gen.sv
// -----------------------------------------------------------------------------
// tex_addr_gen
// Converts per-lane fixed-point (u,v) into wrapped texel byte addresses using
// the selected texture stage state. Two-stage valid/ready pipeline:
//   stage 0: scale + wrap, captures the stage fields it needs
//   stage 1: base + offset add; its register drives the response outputs
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   tex_csrs              per-stage texture state from the CSR block
//   req_valid/req_ready   request handshake
//   req_stage             texture stage index
//   req_mask              active lanes
//   req_u, req_v          signed fixed-point coordinates per lane
//   req_tag               opaque tag, passed through
//   rsp_valid/rsp_ready   response handshake
//   rsp_mask, rsp_tag     copies of the request mask and tag
//   rsp_addr              texel byte address per lane (0 for inactive lanes)
// -----------------------------------------------------------------------------
module tex_addr_gen
    import tex_addr_gen_pkg::*;
#(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned TAG_WIDTH = 8,
    parameter int unsigned FRAC_BITS = 20
) (
    input  logic                            clk,
    input  logic                            reset,
    input  tex_csrs_t                       tex_csrs,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [TEX_STAGE_BITS-1:0]       req_stage,
    input  logic [NUM_LANES-1:0]            req_mask,
    input  logic [NUM_LANES-1:0][31:0]      req_u,
    input  logic [NUM_LANES-1:0][31:0]      req_v,
    input  logic [TAG_WIDTH-1:0]            req_tag,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [NUM_LANES-1:0]            rsp_mask,
    output logic [NUM_LANES-1:0][31:0]      rsp_addr,
    output logic [TAG_WIDTH-1:0]            rsp_tag
);

    tex_stage_t                                stage;
    logic [3:0]                                logw;
    logic [3:0]                                logh;
    logic [4:0]                                shamt_u;
    logic [4:0]                                shamt_v;
    logic [NUM_LANES-1:0][TEX_COORD_BITS-1:0]  x_d;
    logic [NUM_LANES-1:0][TEX_COORD_BITS-1:0]  y_d;
    logic                                      accept;
    logic                                      s1_ready;

    // Stage 0 registers
    logic                                      s0_valid;
    logic [31:0]                               s0_base;
    logic [3:0]                                s0_logw;
    logic [1:0]                                s0_logstride;
    logic [NUM_LANES-1:0]                      s0_mask;
    logic [TAG_WIDTH-1:0]                      s0_tag;
    logic [NUM_LANES-1:0][TEX_COORD_BITS-1:0]  s0_x;
    logic [NUM_LANES-1:0][TEX_COORD_BITS-1:0]  s0_y;

    logic [NUM_LANES-1:0][31:0]                addr_d;

    // Handshake: ready never depends on req_valid.
    assign s1_ready  = !rsp_valid || rsp_ready;
    assign req_ready = !s0_valid || s1_ready;
    assign accept    = req_valid && req_ready;

    // Stage 0: scale and wrap
    assign stage   = tex_csrs[req_stage];
    assign logw    = tex_log_sat(stage.logwidth);
    assign logh    = tex_log_sat(stage.logheight);
    // Shifting by (FRAC_BITS - log) leaves the integer texel coordinate.
    assign shamt_u = 5'(FRAC_BITS) - {1'b0, logw};
    assign shamt_v = 5'(FRAC_BITS) - {1'b0, logh};

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic signed [31:0] xf;
        logic signed [31:0] yf;

        assign xf = $signed(req_u[l]) >>> shamt_u;
        assign yf = $signed(req_v[l]) >>> shamt_v;

        tex_wrap u_wrap_x (
            .xf       (xf),
            .log_size (logw),
            .mode     (stage.wrap_u),
            .coord    (x_d[l])
        );

        tex_wrap u_wrap_y (
            .xf       (yf),
            .log_size (logh),
            .mode     (stage.wrap_v),
            .coord    (y_d[l])
        );
    end

    // Stage-0 payload only loads on acceptance, so later CSR writes never
    // reach a request already in flight.
    always_ff @(posedge clk) begin
        if (accept) begin
            s0_base      <= stage.addr;
            s0_logw      <= logw;
            s0_logstride <= stage.logstride;
            s0_mask      <= req_mask;
            s0_tag       <= req_tag;
            s0_x         <= x_d;
            s0_y         <= y_d;
        end
    end

    // Stage 1: address add, inactive lanes forced to zero
    always_comb begin
        addr_d = '0;
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            if (s0_mask[l]) begin
                addr_d[l] = s0_base + tex_texel_offset(s0_x[l], s0_y[l], s0_logw, s0_logstride);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s0_valid  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_mask  <= '0;
            rsp_addr  <= '0;
            rsp_tag   <= '0;
        end else begin
            if (req_ready) begin
                s0_valid <= req_valid;
            end
            if (s1_ready) begin
                rsp_valid <= s0_valid;
                if (s0_valid) begin
                    rsp_mask <= s0_mask;
                    rsp_addr <= addr_d;
                    rsp_tag  <= s0_tag;
                end
            end
        end
    end

endmodule

// File: tb/tb_tex_addr_gen.sv
module tb_tex_addr_gen;
    import tex_addr_gen_pkg::*;

    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned TAG_WIDTH = 8;
    localparam int unsigned FRAC_BITS = 20;

    typedef logic [NUM_LANES-1:0][31:0] lanes_t;
    typedef struct {
        logic [NUM_LANES-1:0] mask;
        lanes_t               addr;
        logic [TAG_WIDTH-1:0] tag;
    } exp_t;

    logic                        clk = 1'b0;
    logic                        reset = 1'b1;
    tex_csrs_t                   tex_csrs;
    logic                        req_valid = 1'b0;
    logic                        req_ready;
    logic [TEX_STAGE_BITS-1:0]   req_stage = '0;
    logic [NUM_LANES-1:0]        req_mask = '0;
    lanes_t                      req_u = '0;
    lanes_t                      req_v = '0;
    logic [TAG_WIDTH-1:0]        req_tag = '0;
    logic                        rsp_valid;
    logic                        rsp_ready = 1'b0;
    logic [NUM_LANES-1:0]        rsp_mask;
    lanes_t                      rsp_addr;
    logic [TAG_WIDTH-1:0]        rsp_tag;

    int          compared = 0;
    int          mismatched = 0;
    exp_t        exp_q[$];
    logic [31:0] got_addr0[$];
    int          n_rsp = 0;
    bit          accepted = 0;
    bit          stall_prev = 0;
    logic [NUM_LANES-1:0] hold_mask;
    lanes_t      hold_addr;
    logic [TAG_WIDTH-1:0] hold_tag;
    lanes_t      last_addr;
    logic [TAG_WIDTH-1:0] tag_ctr = '0;

    tex_addr_gen #(
        .NUM_LANES (NUM_LANES),
        .TAG_WIDTH (TAG_WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tex_csrs  (tex_csrs),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_stage (req_stage),
        .req_mask  (req_mask),
        .req_u     (req_u),
        .req_v     (req_v),
        .req_tag   (req_tag),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_mask  (rsp_mask),
        .rsp_addr  (rsp_addr),
        .rsp_tag   (rsp_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the texture rules.
    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic longint wrap_ref(input longint c, input longint w, input tex_wrap_e mode);
        longint m;
        case (mode)
            TEX_WRAP_REPEAT: begin
                m = c % w;
                if (m < 0) m = m + w;
                return m;
            end
            TEX_WRAP_MIRROR: begin
                m = c % (2 * w);
                if (m < 0) m = m + 2 * w;
                return (m < w) ? m : (2 * w - 1 - m);
            end
            default: return (c < 0) ? 0 : ((c >= w) ? w - 1 : c);
        endcase
    endfunction

    function automatic logic [31:0] ref_addr(input tex_stage_t st, input logic [31:0] u,
                                             input logic [31:0] v);
        longint w, h, x, y, off;
        w = longint'(1) << ((st.logwidth > 12) ? 12 : st.logwidth);
        h = longint'(1) << ((st.logheight > 12) ? 12 : st.logheight);
        x = wrap_ref(floor_div(longint'($signed(u)) * w, longint'(1) << FRAC_BITS), w, st.wrap_u);
        y = wrap_ref(floor_div(longint'($signed(v)) * h, longint'(1) << FRAC_BITS), h, st.wrap_v);
        off = (y * w + x) * (longint'(1) << st.logstride);
        return 32'(longint'(st.addr) + off);
    endfunction

    // One cycle: sample at negedge+1, score responses, check stall stability,
    // record acceptance, then advance to the next negedge.
    task automatic tick();
        exp_t e;
        #1;
        if (stall_prev) begin
            chk("hold_valid", 32'(rsp_valid), 1);
            chk("hold_mask", 32'(rsp_mask), 32'(hold_mask));
            chk("hold_tag", 32'(rsp_tag), 32'(hold_tag));
            for (int l = 0; l < NUM_LANES; l++)
                chk($sformatf("hold_addr%0d", l), rsp_addr[l], hold_addr[l]);
        end
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("rsp_with_empty_queue", 32'(rsp_valid), 0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_mask", 32'(rsp_mask), 32'(e.mask));
                chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
                for (int l = 0; l < NUM_LANES; l++)
                    chk($sformatf("rsp_addr%0d", l), rsp_addr[l], e.addr[l]);
                last_addr = rsp_addr;
                got_addr0.push_back(rsp_addr[0]);
                n_rsp++;
            end
        end
        stall_prev = rsp_valid && !rsp_ready;
        hold_mask  = rsp_mask;
        hold_addr  = rsp_addr;
        hold_tag   = rsp_tag;
        accepted   = req_valid && req_ready;
        if (accepted) begin
            e.mask = req_mask;
            e.tag  = req_tag;
            for (int l = 0; l < NUM_LANES; l++)
                e.addr[l] = req_mask[l] ? ref_addr(tex_csrs[req_stage], req_u[l], req_v[l]) : 32'h0;
            exp_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_stage(input int idx, input logic [31:0] addr, input logic [3:0] lw,
                             input logic [3:0] lh, input logic [1:0] ls,
                             input tex_wrap_e wu, input tex_wrap_e wv);
        tex_csrs[idx].addr      = addr;
        tex_csrs[idx].logwidth  = lw;
        tex_csrs[idx].logheight = lh;
        tex_csrs[idx].logstride = ls;
        tex_csrs[idx].wrap_u    = wu;
        tex_csrs[idx].wrap_v    = wv;
    endtask

    // Single isolated request on stage 0 with latency and literal checks.
    task automatic single(input string name, input lanes_t u, input lanes_t v,
                          input logic [3:0] mask, input lanes_t want);
        req_u = u; req_v = v; req_mask = mask; req_stage = '0;
        req_tag = tag_ctr; tag_ctr++;
        req_valid = 1'b1; rsp_ready = 1'b1;
        tick();
        chk({name, "_accept"}, 32'(accepted), 1);
        req_valid = 1'b0;
        chk({name, "_lat1"}, 32'(rsp_valid), 0);
        tick();
        chk({name, "_lat2"}, 32'(rsp_valid), 1);
        tick();
        for (int l = 0; l < NUM_LANES; l++)
            chk($sformatf("%s_lit%0d", name, l), last_addr[l], want[l]);
    endtask

    function automatic logic [31:0] rand_coord();
        case ($urandom_range(0, 2))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 32'h800000)) - 32'h400000;
            default: return 32'($urandom_range(0, 32'h100000));
        endcase
    endfunction

    task automatic rand_req();
        req_stage = TEX_STAGE_BITS'($urandom_range(0, TEX_NUM_STAGES - 1));
        req_mask  = NUM_LANES'($urandom);
        for (int l = 0; l < NUM_LANES; l++) begin
            req_u[l] = rand_coord();
            req_v[l] = rand_coord();
        end
        req_tag = tag_ctr; tag_ctr++;
    endtask

    task automatic drain(input string name);
        req_valid = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 12 && exp_q.size() != 0; i++) tick();
        chk({name, "_drained"}, 32'(exp_q.size()), 0);
    endtask

    initial begin
        int n0;
        int guard;
        int cyc;

        for (int s = 0; s < TEX_NUM_STAGES; s++)
            set_stage(s, 32'h1000, 4'd2, 4'd2, 2'd2, TEX_WRAP_CLAMP, TEX_WRAP_CLAMP);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_mask", 32'(rsp_mask), 0);
        chk("rst_rsp_tag", 32'(rsp_tag), 0);
        chk("rst_rsp_addr0", rsp_addr[0], 0);
        chk("rst_req_ready", 32'(req_ready), 1);
        @(negedge clk);

        // Directed vectors
        single("clamp_basic", {4{32'h80000}}, {4{32'h40000}}, 4'hF, {4{32'h1018}});
        set_stage(0, 32'h1000, 4'd2, 4'd2, 2'd2, TEX_WRAP_REPEAT, TEX_WRAP_CLAMP);
        single("repeat_u", {4{32'h140000}}, {4{32'h0}}, 4'hF, {4{32'h1004}});
        set_stage(0, 32'h1000, 4'd2, 4'd2, 2'd2, TEX_WRAP_MIRROR, TEX_WRAP_CLAMP);
        single("mirror_u", {4{32'h140000}}, {4{32'h0}}, 4'hF, {4{32'h1008}});
        set_stage(0, 32'h1000, 4'd2, 4'd2, 2'd2, TEX_WRAP_CLAMP, TEX_WRAP_CLAMP);
        single("clamp_mask", {32'h140000, 32'h80000, 32'h180000, 32'hFFFC0000}, {4{32'h0}},
               4'b0101, {32'h0, 32'h1008, 32'h0, 32'h1000});
        single("clamp_edges", {32'h140000, 32'h80000, 32'h180000, 32'hFFFC0000}, {4{32'h0}},
               4'hF, {32'h100C, 32'h1008, 32'h100C, 32'h1000});
        // logwidth above 12 saturates: width 4096, u=0.5 -> x=2048
        set_stage(0, 32'h1000, 4'd15, 4'd0, 2'd0, TEX_WRAP_REPEAT, TEX_WRAP_CLAMP);
        single("logw_sat", {4{32'h80000}}, {4{32'h0}}, 4'hF, {4{32'h1800}});
        set_stage(0, 32'h1000, 4'd2, 4'd2, 2'd2, TEX_WRAP_CLAMP, TEX_WRAP_CLAMP);

        // Full throughput: one accept per cycle
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rand_req();
            req_valid = 1'b1;
            #1;
            chk("full_rate_ready", 32'(req_ready), 1);
            tick();
        end
        drain("full_rate");

        // Back-pressure: tags 0..7 with rsp_ready toggling
        n0 = n_rsp;
        cyc = 0;
        for (int i = 0; i < 8; i++) begin
            rand_req();
            req_stage = '0;
            req_tag = TAG_WIDTH'(i);
            req_valid = 1'b1;
            guard = 0;
            do begin
                rsp_ready = (cyc % 2) == 0;
                cyc++;
                tick();
                guard++;
            end while (!accepted && guard < 20);
            chk("bp_accept", 32'(accepted), 1);
        end
        drain("bp");
        chk("bp_count", 32'(n_rsp - n0), 8);

        // CSR change while a request is in flight
        got_addr0.delete();
        req_stage = '0; req_mask = 4'hF; req_u = '0; req_v = '0;
        req_valid = 1'b1; rsp_ready = 1'b1;
        tick();
        tex_csrs[0].addr = 32'h2000;
        tick();
        drain("csr_change");
        chk("csr_count", 32'(got_addr0.size()), 2);
        if (got_addr0.size() == 2) begin
            chk("csr_old_base", got_addr0[0], 32'h1000);
            chk("csr_new_base", got_addr0[1], 32'h2000);
        end

        // Randomized traffic over all stages
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0)
                set_stage($urandom_range(0, TEX_NUM_STAGES - 1), $urandom,
                          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          2'($urandom_range(0, 3)), tex_wrap_e'($urandom_range(0, 3)),
                          tex_wrap_e'($urandom_range(0, 3)));
            if (!req_valid || accepted) begin
                rand_req();
                req_valid = $urandom_range(0, 3) != 0;
            end
            rsp_ready = $urandom_range(0, 3) != 0;
            tick();
        end
        drain("random");

        // Reset with two requests in flight
        rsp_ready = 1'b0;
        rand_req();
        req_valid = 1'b1;
        tick();
        rand_req();
        tick();
        req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        stall_prev = 0;
        #1;
        chk("rst2_rsp_valid", 32'(rsp_valid), 0);
        chk("rst2_rsp_mask", 32'(rsp_mask), 0);
        chk("rst2_rsp_tag", 32'(rsp_tag), 0);
        for (int l = 0; l < NUM_LANES; l++)
            chk($sformatf("rst2_rsp_addr%0d", l), rsp_addr[l], 0);
        chk("rst2_req_ready", 32'(req_ready), 1);
        @(negedge clk);
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst2_quiet", 32'(rsp_valid), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/tex_addr_gen.md
# tex_addr_gen

Texture address generator directly downstream of the texture CSR block. It consumes the per-stage texture state published as `tex_csrs` and converts per-lane fixed-point (u,v) coordinates into wrapped texel byte addresses. It sits between the texture request front-end and the texture memory/fetch unit, as a 2-stage valid/ready pipeline.

## Interface
- `NUM_LANES`, 4, lanes per request
- `TAG_WIDTH`, 8, opaque request tag passed through
- `FRAC_BITS`, 20, fractional bits of u/v; 1.0 = 1<<FRAC_BITS
- `clk` in 1: clock; single clock domain
- `reset` in 1: synchronous, active-high reset
- `tex_csrs` in `tex_csrs_t`: per-stage texture state from the CSR block
- `req_valid` in 1: request valid
- `req_ready` out 1: request accepted when valid&&ready
- `req_stage` in `TEX_STAGE_BITS`: texture stage index
- `req_mask` in NUM_LANES: active lanes
- `req_u`, `req_v` in NUM_LANES×32: signed fixed-point coordinates
- `req_tag` in TAG_WIDTH: passthrough tag
- `rsp_valid` out 1: response valid
- `rsp_ready` in 1: downstream accepts
- `rsp_mask` out NUM_LANES: copy of req_mask
- `rsp_addr` out NUM_LANES×32: texel byte addresses
- `rsp_tag` out TAG_WIDTH: copy of req_tag

## Operation
- Stage fields used: `addr[31:0]`, `logwidth[3:0]`, `logheight[3:0]`, `logstride[1:0]` (texel bytes = 1<<logstride), `wrap_u[1:0]`, `wrap_v[1:0]`.
- Fields of `req_stage` are captured into stage 0 at acceptance; later CSR writes never affect in-flight requests.
- Scale: `xf = req_u >>> (FRAC_BITS - logwidth)` (arithmetic); likewise `yf` with logheight. `W = 1<<logwidth`.
- Wrap per axis: CLAMP (0): xf<0 → 0, xf≥W → W-1, else xf. REPEAT (1): xf & (W-1). MIRROR (2): bit[logwidth] of xf set → (W-1)-(xf&(W-1)), else xf&(W-1). Mode 3 reserved, behaves as CLAMP.
- logwidth/logheight > 12 saturate to 12.
- Address: `addr + (((y << logwidth) | x) << logstride)`, 32-bit modulo 2^32.
- Inactive lanes (mask bit 0): `rsp_addr` lane = 0.

## Timing
- Stage 0 (accept → register): scale + wrap; stage 1: address add; output is the stage-1 register. Latency 2 cycles from accept to `rsp_valid`, no bubbles at full throughput (1 req/cycle).
- `req_ready = !s0_valid || s1_ready`; `s1_ready = !rsp_valid || rsp_ready`. No combinational path from `req_valid` to `req_ready`.
- Stall: while `rsp_valid && !rsp_ready`, all output fields hold stable; stage 0 holds if occupied.
- Simultaneous accept and drain on a full pipe: both occur, no data loss or duplication.
- Reset: `rsp_valid`=0, `rsp_mask`=0, `rsp_addr`=0, `rsp_tag`=0, stage valids cleared; in-flight requests dropped; `req_ready`=1 the cycle after reset deasserts.

## Structure
- `tex_csrs_t`, per-stage struct, `TEX_STAGE_BITS` and wrap-mode constants (`TEX_WRAP_CLAMP/REPEAT/MIRROR`) live in the shared texture define/package, alongside the CSR block.
- One sub-module: `tex_wrap` (combinational, one axis/lane: xf, log size, mode → wrapped coord), instantiated 2×NUM_LANES.
- Pipeline registers kept in the top module.

## Test plan
- Stage 0: addr=0x1000, logw=logh=2, logstride=2, CLAMP; u=0x80000, v=0x40000 → x=2,y=1, rsp_addr=0x1018 two cycles after accept.
- REPEAT u: u=0x140000 (1.25), v=0 → x=1, addr=0x1004; MIRROR u same → x=2, addr=0x1008.
- CLAMP: u=0xFFFC0000 (-0.25) → x=0; u=0x180000 (1.5) → x=3; mask=4'b0101 → lanes 1,3 addr=0.
- Back-pressure: stream 8 requests tags 0..7, rsp_ready toggled 1/0 → all 8 responses in order, no loss, outputs stable while stalled.
- CSR change mid-flight: accept request, change stage addr to 0x2000 next cycle → response uses 0x1000; next request uses 0x2000.
- Reset with 2 requests in flight → no rsp_valid after reset, all outputs 0, req_ready=1.
